// File: rtl/voter_pkg.sv
// Shared types and helpers for the voting session block: FSM states, verdict
// encodings and the majority rule.
package voter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        TALLY   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [2:0] RES_REJECT  = 3'b100;
    localparam logic [2:0] RES_TIE     = 3'b010;
    localparam logic [2:0] RES_APPROVE = 3'b001;

    // Compares 2*y against n one bit wider than the operands so doubling never wraps.
    function automatic logic [2:0] verdict(input int unsigned y, input int unsigned n);
        logic [32:0] twice_y;
        logic [32:0] n_ext;
        twice_y = {y, 1'b0};
        n_ext   = {1'b0, n};
        if (twice_y > n_ext) begin
            return RES_APPROVE;
        end else if (twice_y == n_ext) begin
            return RES_TIE;
        end
        return RES_REJECT;
    endfunction

endpackage

// File: rtl/voter_session_popcount.sv
// Combinational population count of a W-bit vector into a CW-bit result.
module voter_popcount #(
    parameter int unsigned W  = 4,
    parameter int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  vec,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(vec[i]);
        end
    end

endmodule

// File: rtl/voter_session.sv
// Voting session controller: collects one ballot per voter until everyone has
// voted or the collection window expires, then tallies and holds the verdict.
module voter_session
    import voter_pkg::*;
#(
    parameter int unsigned N_VOTERS       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = $clog2(N_VOTERS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_VOTERS-1:0] vote_valid,
    input  logic [N_VOTERS-1:0] vote_yes,
    output logic [N_VOTERS-1:0] vote_ack,
    output logic                busy,
    output logic                result_valid,
    output logic [2:0]          result,
    output logic [CNT_W-1:0]    yes_count,
    output logic [CNT_W-1:0]    voted_count,
    output logic                timed_out
);

    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t              state_q;
    logic [N_VOTERS-1:0] voted_q;
    logic [N_VOTERS-1:0] ballots_q;
    logic [TIMER_W-1:0]  timer_q;

    logic [N_VOTERS-1:0] accept;
    logic [N_VOTERS-1:0] voted_d;
    logic [N_VOTERS-1:0] ballots_d;
    logic                all_voted;
    logic                timer_expired;
    logic [CNT_W-1:0]    y_cnt;
    logic [CNT_W-1:0]    v_cnt;

    // Unvoted voters keep a 0 ballot, so a timeout close counts them as NO.
    always_comb begin
        accept        = (state_q == COLLECT) ? (vote_valid & ~voted_q) : '0;
        voted_d       = voted_q | accept;
        ballots_d     = ballots_q | (accept & vote_yes);
        all_voted     = &voted_d;
        timer_expired = (timer_q == TIMER_LAST);
    end

    assign vote_ack     = accept;
    assign busy         = (state_q == COLLECT) || (state_q == TALLY);
    assign result_valid = (state_q == DONE);

    voter_popcount #(
        .W  (N_VOTERS),
        .CW (CNT_W)
    ) u_yes_pop (
        .vec   (ballots_q),
        .count (y_cnt)
    );

    voter_popcount #(
        .W  (N_VOTERS),
        .CW (CNT_W)
    ) u_voted_pop (
        .vec   (voted_q),
        .count (v_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            voted_q     <= '0;
            ballots_q   <= '0;
            timer_q     <= '0;
            result      <= 3'b000;
            yes_count   <= '0;
            voted_count <= '0;
            timed_out   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q     <= COLLECT;
                        voted_q     <= '0;
                        ballots_q   <= '0;
                        timer_q     <= '0;
                        result      <= 3'b000;
                        yes_count   <= '0;
                        voted_count <= '0;
                        timed_out   <= 1'b0;
                    end
                end
                COLLECT: begin
                    voted_q   <= voted_d;
                    ballots_q <= ballots_d;
                    timer_q   <= timer_q + TIMER_W'(1);
                    // A full mask on the expiry edge is a normal close, not a timeout.
                    if (all_voted) begin
                        state_q   <= TALLY;
                        timed_out <= 1'b0;
                    end else if (timer_expired) begin
                        state_q   <= TALLY;
                        timed_out <= 1'b1;
                    end
                end
                TALLY: begin
                    state_q     <= DONE;
                    yes_count   <= y_cnt;
                    voted_count <= v_cnt;
                    result      <= verdict(32'(y_cnt), N_VOTERS);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voter_session.sv
// Self-checking bench for voter_session: vector table, directed corner cases
// and randomized sessions against a behavioural model.
module tb_voter_session;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance a: N=4, TIMEOUT=16
    logic       start_a;
    logic [3:0] valid_a, yes_a, ack_a;
    logic       busy_a, rv_a, to_a;
    logic [2:0] res_a, yc_a, vc_a;

    // Instance b: N=5, TIMEOUT=16
    logic       start_b;
    logic [4:0] valid_b, yes_b, ack_b;
    logic       busy_b, rv_b, to_b;
    logic [2:0] res_b, yc_b, vc_b;

    // Instance c: N=4, TIMEOUT=4
    logic       start_c;
    logic [3:0] valid_c, yes_c, ack_c;
    logic       busy_c, rv_c, to_c;
    logic [2:0] res_c, yc_c, vc_c;

    voter_session #(.N_VOTERS(4), .TIMEOUT_CYCLES(16)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .vote_valid(valid_a), .vote_yes(yes_a),
        .vote_ack(ack_a), .busy(busy_a), .result_valid(rv_a), .result(res_a),
        .yes_count(yc_a), .voted_count(vc_a), .timed_out(to_a)
    );

    voter_session #(.N_VOTERS(5), .TIMEOUT_CYCLES(16)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .vote_valid(valid_b), .vote_yes(yes_b),
        .vote_ack(ack_b), .busy(busy_b), .result_valid(rv_b), .result(res_b),
        .yes_count(yc_b), .voted_count(vc_b), .timed_out(to_b)
    );

    voter_session #(.N_VOTERS(4), .TIMEOUT_CYCLES(4)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .vote_valid(valid_c), .vote_yes(yes_c),
        .vote_ack(ack_c), .busy(busy_c), .result_valid(rv_c), .result(res_c),
        .yes_count(yc_c), .voted_count(vc_c), .timed_out(to_c)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] yes;
        logic [2:0] res;
        int         yc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] model_verdict(input int y, input int n);
        if (2 * y > n) return 3'b001;
        if (2 * y == n) return 3'b010;
        return 3'b100;
    endfunction

    task automatic wait_rv_a(output int n);
        n = 0;
        while (!rv_a && n < 64) begin
            tick();
            n++;
        end
        check("a_done_bound", 32'(rv_a), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n;
        int   cyc;
        int   sparsity;
        int   my, mv;
        bit   closed, all;
        bit   m_voted[4];
        bit   m_yes[4];
        logic [3:0] v, y, exp_ack;

        vecs[0] = '{yes: 4'b0111, res: 3'b001, yc: 3};
        vecs[1] = '{yes: 4'b0011, res: 3'b010, yc: 2};
        vecs[2] = '{yes: 4'b0001, res: 3'b100, yc: 1};
        vecs[3] = '{yes: 4'b0000, res: 3'b100, yc: 0};
        vecs[4] = '{yes: 4'b1111, res: 3'b001, yc: 4};
        vecs[5] = '{yes: 4'b1010, res: 3'b010, yc: 2};

        rst = 1'b1;
        start_a = 0; valid_a = '0; yes_a = '0;
        start_b = 0; valid_b = '0; yes_b = '0;
        start_c = 0; valid_c = '0; yes_c = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy_a), 0);
        check("rst_rv", 32'(rv_a), 0);
        check("rst_res", 32'(res_a), 0);
        check("rst_yc", 32'(yc_a), 0);
        check("rst_vc", 32'(vc_a), 0);
        check("rst_to", 32'(to_a), 0);
        rst = 1'b0;
        valid_a = 4'hF;
        #1;
        check("idle_no_ack", 32'(ack_a), 0);
        valid_a = '0;

        // All four ballots in one cycle
        for (int i = 0; i < 6; i++) begin
            start_a = 1; tick(); start_a = 0;
            valid_a = 4'hF; yes_a = vecs[i].yes;
            #1;
            check("tbl_ack", 32'(ack_a), 32'hF);
            check("tbl_busy", 32'(busy_a), 1);
            tick();
            valid_a = '0;
            check("tbl_tally_busy", 32'(busy_a), 1);
            check("tbl_tally_rv", 32'(rv_a), 0);
            tick();
            check("tbl_rv", 32'(rv_a), 1);
            check("tbl_busy_done", 32'(busy_a), 0);
            check("tbl_res", 32'(res_a), 32'(vecs[i].res));
            check("tbl_yc", 32'(yc_a), 32'(vecs[i].yc));
            check("tbl_vc", 32'(vc_a), 4);
            check("tbl_to", 32'(to_a), 0);
        end

        // Timeout with two yes ballots
        start_a = 1; tick(); start_a = 0;
        valid_a = 4'b0101; yes_a = 4'b0101;
        #1;
        check("to_ack", 32'(ack_a), 32'b0101);
        tick();
        valid_a = '0;
        wait_rv_a(n);
        check("to_latency", 32'(n + 1), 17);
        check("to_flag", 32'(to_a), 1);
        check("to_res", 32'(res_a), 32'b010);
        check("to_yc", 32'(yc_a), 2);
        check("to_vc", 32'(vc_a), 2);
        valid_a = 4'hF;
        #1;
        check("done_no_ack", 32'(ack_a), 0);
        tick(); tick();
        valid_a = '0;
        check("done_hold_vc", 32'(vc_a), 2);
        check("done_hold_rv", 32'(rv_a), 1);

        // Repeat ballot ignored
        start_a = 1; tick(); start_a = 0;
        check("restart_rv_drop", 32'(rv_a), 0);
        check("restart_res_clr", 32'(res_a), 0);
        valid_a = 4'b0010; yes_a = 4'b0010;
        #1;
        check("rep_ack1", 32'(ack_a), 32'b0010);
        tick();
        valid_a = 4'b0010; yes_a = 4'b0000;
        #1;
        check("rep_ack2", 32'(ack_a), 0);
        tick();
        valid_a = 4'b1101; yes_a = 4'b0000;
        #1;
        check("rep_ack3", 32'(ack_a), 32'b1101);
        tick();
        valid_a = '0;
        tick();
        check("rep_rv", 32'(rv_a), 1);
        check("rep_yc", 32'(yc_a), 1);
        check("rep_vc", 32'(vc_a), 4);
        check("rep_res", 32'(res_a), 32'b100);

        // N=5: approve then reject after restart
        start_b = 1; tick(); start_b = 0;
        valid_b = 5'h1F; yes_b = 5'b00111;
        #1;
        check("b5_ack", 32'(ack_b), 32'h1F);
        tick(); valid_b = '0; tick();
        check("b5_rv", 32'(rv_b), 1);
        check("b5_res_app", 32'(res_b), 32'b001);
        check("b5_yc", 32'(yc_b), 3);
        start_b = 1; tick(); start_b = 0;
        check("b5_rv_drop", 32'(rv_b), 0);
        check("b5_busy", 32'(busy_b), 1);
        valid_b = 5'h1F; yes_b = 5'b11000;
        tick(); valid_b = '0; tick();
        check("b5_res_rej", 32'(res_b), 32'b100);
        check("b5_yc2", 32'(yc_b), 2);
        check("b5_vc2", 32'(vc_b), 5);

        // TIMEOUT=4: last voter on the final collect cycle
        start_c = 1; tick(); start_c = 0;
        for (int i = 0; i < 4; i++) begin
            valid_c = 4'(1 << i); yes_c = 4'(1 << i);
            #1;
            check("sim_ack", 32'(ack_c), 32'(1 << i));
            tick();
        end
        valid_c = '0;
        check("sim_tally_rv", 32'(rv_c), 0);
        tick();
        check("sim_rv", 32'(rv_c), 1);
        check("sim_to", 32'(to_c), 0);
        check("sim_vc", 32'(vc_c), 4);
        check("sim_res", 32'(res_c), 32'b001);
        // TIMEOUT=4 with nobody voting
        start_c = 1; tick(); start_c = 0;
        repeat (4) tick();
        check("c_to_busy", 32'(busy_c), 1);
        tick();
        check("c_to_rv", 32'(rv_c), 1);
        check("c_to_flag", 32'(to_c), 1);
        check("c_to_vc", 32'(vc_c), 0);
        check("c_to_res", 32'(res_c), 32'b100);

        // Randomized sessions against the model
        for (int s = 0; s < 25; s++) begin
            sparsity = $urandom_range(1, 3);
            start_a = 1; tick(); start_a = 0;
            for (int i = 0; i < 4; i++) begin
                m_voted[i] = 0;
                m_yes[i]   = 0;
            end
            cyc = 0;
            closed = 0;
            all = 0;
            while (!closed) begin
                v = 4'($urandom());
                for (int k = 1; k < sparsity; k++) v = v & 4'($urandom());
                y = 4'($urandom());
                start_a = ($urandom_range(0, 3) == 0);
                valid_a = v; yes_a = y;
                #1;
                exp_ack = '0;
                for (int i = 0; i < 4; i++) begin
                    if (v[i] && !m_voted[i]) begin
                        exp_ack[i] = 1'b1;
                        m_voted[i] = 1;
                        m_yes[i]   = y[i];
                    end
                end
                check("rnd_ack", 32'(ack_a), 32'(exp_ack));
                check("rnd_busy", 32'(busy_a), 1);
                cyc++;
                all = 1;
                for (int i = 0; i < 4; i++) all = all & m_voted[i];
                closed = all || (cyc == 16);
                tick();
            end
            start_a = 0; valid_a = '0;
            check("rnd_tally_rv", 32'(rv_a), 0);
            tick();
            my = 0; mv = 0;
            for (int i = 0; i < 4; i++) begin
                my += int'(m_yes[i]);
                mv += int'(m_voted[i]);
            end
            check("rnd_rv", 32'(rv_a), 1);
            check("rnd_res", 32'(res_a), 32'(model_verdict(my, 4)));
            check("rnd_yc", 32'(yc_a), 32'(my));
            check("rnd_vc", 32'(vc_a), 32'(mv));
            check("rnd_to", 32'(to_a), 32'(!all));
        end

        // Reset mid-collect discards partial ballots
        start_a = 1; tick(); start_a = 0;
        valid_a = 4'b0011; yes_a = 4'b0011;
        tick();
        valid_a = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        valid_a = 4'hF;
        #1;
        check("mid_rst_ack", 32'(ack_a), 0);
        check("mid_rst_busy", 32'(busy_a), 0);
        check("mid_rst_rv", 32'(rv_a), 0);
        check("mid_rst_yc", 32'(yc_a), 0);
        check("mid_rst_vc", 32'(vc_a), 0);
        valid_a = '0;
        start_a = 1; tick(); start_a = 0;
        valid_a = 4'b1100; yes_a = 4'b1100;
        tick();
        valid_a = 4'b0011; yes_a = 4'b0000;
        #1;
        check("post_rst_ack", 32'(ack_a), 32'b0011);
        tick();
        valid_a = '0;
        tick();
        check("post_rst_yc", 32'(yc_a), 2);
        check("post_rst_vc", 32'(vc_a), 4);
        check("post_rst_res", 32'(res_a), 32'b010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/voter_session.md
Name: voter_session

Overview:
- Sequential, parametrised successor to the 4-input combinational majority voter.
- Runs a voting session: opens on start, collects at most one ballot per voter over a valid handshake, and closes when all voters have voted or a timeout expires.
- Tallies the ballots and holds the one-hot reject/tie/approve verdict until the next session.
- Sits between per-voter ballot sources and downstream decision logic.

Parameters:
- N_VOTERS, 4, number of voters (2..32).
- TIMEOUT_CYCLES, 16, COLLECT cycles allowed before forced close (>=1).
- CNT_W, $clog2(N_VOTERS+1), width of the yes/vote counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  opens a session; honoured only in IDLE or DONE.
- vote_valid  in  N_VOTERS  per-voter ballot strobe.
- vote_yes  in  N_VOTERS  per-voter ballot value, sampled when vote_valid[i]=1; 1=yes, 0=no.
- vote_ack  out  N_VOTERS  one-cycle pulse: ballot i accepted this cycle.
- busy  out  1  high in COLLECT and TALLY.
- result_valid  out  1  high in DONE.
- result  out  3  one-hot verdict: bit2=reject, bit1=tie, bit0=approve.
- yes_count  out  CNT_W  number of yes ballots accepted in the session.
- voted_count  out  CNT_W  number of ballots accepted in the session.
- timed_out  out  1  session closed by timeout; valid while result_valid=1.

Behaviour:
- Reset: state=IDLE; vote_ack=0, busy=0, result_valid=0, result=3'b000, yes_count=0, voted_count=0, timed_out=0; ballot registers and voted mask cleared.
- States: IDLE, COLLECT, TALLY, DONE.
- IDLE -> COLLECT when start=1:
  - clears the voted mask, ballots, counters, timed_out and the timer;
  - result_valid=0 and result=000 in the next cycle.
- DONE -> COLLECT on start=1, with the same clearing. Without start, DONE holds all outputs indefinitely.
- COLLECT, ballot acceptance:
  - each cycle, for every i with vote_valid[i]=1 and voted[i]=0, latch vote_yes[i], set voted[i], and pulse vote_ack[i] in the same cycle (combinational ack, registered capture);
  - repeat ballots from a voter are ignored: no ack, no change;
  - several voters may be accepted in one cycle.
- COLLECT, timer: increments every COLLECT cycle, starting at 0.
- COLLECT -> TALLY at the first clock edge where either:
  - the mask, including this cycle's acceptances, is all-ones; or
  - timer == TIMEOUT_CYCLES-1.
- Timeout and all-voted on the same edge: all-voted wins, timed_out=0.
- On a timeout close, timed_out=1 and voters that did not vote are counted as NO.
- start while COLLECT or TALLY is ignored; vote_valid outside COLLECT is ignored and never acked.
- TALLY (one cycle): compute Y=popcount(yes ballots) and V=popcount(voted), then go to DONE.
- DONE: yes_count=Y, voted_count=V, result_valid=1.
- Verdict rule, with N=N_VOTERS: 2*Y > N -> approve; 2*Y == N -> tie (only possible for even N); 2*Y < N -> reject. Compare at CNT_W+1 bits to avoid overflow.
- For N=4 the verdicts are: Y<=1 reject, Y=2 tie, Y>=3 approve.
- Latency: result_valid rises 2 cycles after the edge on which the last ballot is accepted (COLLECT->TALLY edge, then TALLY->DONE edge).
- busy=1 exactly in COLLECT and TALLY.
- Reset asserted in any state, including mid-COLLECT: returns to IDLE with reset values on the next edge; partial ballots are discarded.

Decomposition:
- Package voter_pkg holds:
  - the state enum (IDLE, COLLECT, TALLY, DONE);
  - result one-hot constants RES_REJECT=3'b100, RES_TIE=3'b010, RES_APPROVE=3'b001;
  - a verdict function taking (Y, N) and returning the 3-bit code.
- One sub-module, voter_popcount (parameter W), combinational, used twice for Y and V.

Test Plan:
- N=4: start; voters 0,1,2 vote yes and voter 3 votes no in one cycle -> 4 acks that cycle, result_valid after 2 cycles, result=001, yes_count=3, voted_count=4, timed_out=0.
- N=4: yes from voters 0 and 2 only, then wait -> timeout after 16 COLLECT cycles, result=010, yes_count=2, voted_count=2, timed_out=1.
- N=4: voter 1 votes yes, then voter 1 votes no again, then the others vote no -> second ballot gets no ack, yes_count=1, result=100.
- N=5 (parameter override): 3 yes, 2 no -> result=001. Then restart with 2 yes, 3 no -> result=100; result_valid drops the cycle after start.
- Simultaneous close, TIMEOUT_CYCLES=4: the last voter votes on the 4th COLLECT cycle -> timed_out=0, voted_count=N.
- Reset mid-COLLECT after 2 ballots -> next cycle IDLE with all outputs 0; a new session starts with counters at 0.
